// File: rtl/alu_cnt_dec_unit.sv
// Datapath utility block: combinational 4-bit ALU with flags, enabled wrapping
// down-counter, and a 3-to-8 one-hot decoder with enable, on one clock domain.
module alu_cnt_dec_unit #(
  parameter int ALU_W = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       alu_fnselec,
  input  logic [ALU_W-1:0] alu_a,
  input  logic [ALU_W-1:0] alu_b,
  output logic [ALU_W-1:0] alu_res,
  output logic             alu_zero,
  output logic             alu_overflow,
  output logic             alu_carry,
  input  logic             counter_en,
  output logic [CNT_W-1:0] dec_counter_out,
  input  logic [2:0]       x,
  input  logic             en,
  output logic [7:0]       y_dec
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NOT = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SLT = 3'b110,
    OP_EQ  = 3'b111
  } alu_op_e;

  localparam int MSB = ALU_W - 1;

  alu_op_e          op;
  logic [ALU_W:0]   sum;
  logic [ALU_W:0]   diff;
  logic             add_ovf;
  logic             sub_ovf;

  assign op = alu_op_e'(alu_fnselec);

  // Both adder paths are always computed; slt reuses the subtractor.
  assign sum     = {1'b0, alu_a} + {1'b0, alu_b};
  assign diff    = {1'b0, alu_a} + {1'b0, ~alu_b} + {{ALU_W{1'b0}}, 1'b1};
  assign add_ovf = (alu_a[MSB] == alu_b[MSB]) && (sum[MSB]  != alu_a[MSB]);
  assign sub_ovf = (alu_a[MSB] != alu_b[MSB]) && (diff[MSB] != alu_a[MSB]);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // it unassigned; that is what keeps this block free of inferred latches.
    alu_res      = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res      = sum[MSB:0];
        alu_carry    = sum[ALU_W];
        alu_overflow = add_ovf;
      end
      OP_SUB: begin
        alu_res      = diff[MSB:0];
        alu_carry    = diff[ALU_W];
        alu_overflow = sub_ovf;
      end
      OP_NOT:  alu_res = ~alu_a;
      OP_AND:  alu_res = alu_a & alu_b;
      OP_OR:   alu_res = alu_a | alu_b;
      OP_XOR:  alu_res = alu_a ^ alu_b;
      OP_SLT:  alu_res = {{(ALU_W-1){1'b0}}, diff[MSB] ^ sub_ovf};
      OP_EQ:   alu_res = {{(ALU_W-1){1'b0}}, alu_a == alu_b};
      default: alu_res = '0;
    endcase
  end

  assign alu_zero = (alu_res == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dec_counter_out <= '1;
    else if (counter_en)
      dec_counter_out <= dec_counter_out - CNT_W'(1);
  end

  assign y_dec = en ? (8'b1 << x) : 8'h00;

endmodule

// File: tb/tb_alu_cnt_dec_unit.sv
// Self-checking bench for alu_cnt_dec_unit: directed corner cases plus random
// stimulus compared against an integer-arithmetic reference model.
module tb_alu_cnt_dec_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] alu_fnselec;
  logic [3:0] alu_a, alu_b, alu_res;
  logic       alu_zero, alu_overflow, alu_carry;
  logic       counter_en;
  logic [2:0] dec_counter_out;
  logic [2:0] x;
  logic       en;
  logic [7:0] y_dec;

  int checks = 0;
  int errors = 0;
  int cnt_m  = 7;

  always #5 clk = ~clk;

  alu_cnt_dec_unit #(.ALU_W(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .alu_fnselec(alu_fnselec), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .counter_en(counter_en), .dec_counter_out(dec_counter_out),
    .x(x), .en(en), .y_dec(y_dec)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference ALU: plain integer arithmetic on unsigned/signed readings.
  task automatic alu_vec(input logic [2:0] fn, input logic [3:0] a, input logic [3:0] b);
    int ua, ub, sa, sb, r, c, v, s;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    r = 0; c = 0; v = 0;
    case (fn)
      3'd0: begin s = ua + ub; c = (s > 15); r = s % 16;
                  v = ((sa + sb) > 7) || ((sa + sb) < -8); end
      3'd1: begin c = (ua >= ub); r = (ua - ub + 16) % 16;
                  v = ((sa - sb) > 7) || ((sa - sb) < -8); end
      3'd2: r = 15 - ua;
      3'd3: r = ua & ub;
      3'd4: r = ua | ub;
      3'd5: r = ua ^ ub;
      3'd6: r = (sa < sb);
      default: r = (ua == ub);
    endcase
    alu_fnselec = fn; alu_a = a; alu_b = b;
    #1;
    check("alu_res",  int'(alu_res),      r);
    check("alu_zero", int'(alu_zero),     int'(r == 0));
    check("alu_carry", int'(alu_carry),   c);
    check("alu_ovf",  int'(alu_overflow), v);
  endtask

  task automatic dec_vec(input logic [2:0] xs, input logic e);
    x = xs; en = e;
    #1;
    check("y_dec", int'(y_dec), e ? (1 << int'(xs)) : 0);
  endtask

  task automatic clock_counter();
    @(posedge clk);
    if (rst) cnt_m = 7;
    else if (counter_en) cnt_m = (cnt_m + 7) % 8;
    #1;
    check("counter", int'(dec_counter_out), cnt_m);
  endtask

  initial begin
    rst = 1'b1; counter_en = 1'b0;
    alu_fnselec = '0; alu_a = '0; alu_b = '0; x = '0; en = 1'b0;

    repeat (2) @(negedge clk);
    check("cnt_reset", int'(dec_counter_out), 7);
    // ALU and decoder must follow inputs while rst is held.
    alu_vec(3'd0, 4'b0111, 4'b0001);
    dec_vec(3'd5, 1'b1);
    rst = 1'b0;

    // Directed ALU corners.
    alu_vec(3'd0, 4'b1111, 4'b0001);
    alu_vec(3'd1, 4'b0000, 4'b0001);
    alu_vec(3'd1, 4'b1000, 4'b0001);
    alu_vec(3'd6, 4'b1000, 4'b0111);
    alu_vec(3'd6, 4'b0111, 4'b1000);
    alu_vec(3'd7, 4'b0101, 4'b0101);
    alu_vec(3'd2, 4'b0000, 4'b0000);
    alu_vec(3'd3, 4'b1100, 4'b1010);
    alu_vec(3'd4, 4'b1100, 4'b1010);
    alu_vec(3'd5, 4'b1100, 4'b1100);
    // Anchor two results with literal values as well as the model.
    alu_fnselec = 3'd0; alu_a = 4'b0111; alu_b = 4'b0001; #1;
    check("add_0111_0001", int'({alu_overflow, alu_carry, alu_zero, alu_res}), 'b1_0_0_1000);
    alu_fnselec = 3'd1; alu_a = 4'b1000; #1;
    check("sub_1000_0001", int'({alu_overflow, alu_res}), 'b1_0111);

    // Decoder sweep, then disabled.
    for (int i = 0; i < 8; i++) dec_vec(3'(i), 1'b1);
    for (int i = 0; i < 8; i += 3) dec_vec(3'(i), 1'b0);

    // Counter: 8 enabled edges wrap back to 7, then hold.
    @(negedge clk); counter_en = 1'b1;
    for (int i = 0; i < 8; i++) clock_counter();
    @(negedge clk); counter_en = 1'b0;
    for (int i = 0; i < 3; i++) clock_counter();
    @(negedge clk); counter_en = 1'b1;
    for (int i = 0; i < 3; i++) clock_counter();

    // Asynchronous reset between edges.
    @(negedge clk); rst = 1'b1;
    #1; check("cnt_async_rst", int'(dec_counter_out), 7);
    #1; rst = 1'b0; cnt_m = 7;
    clock_counter();

    // Random phase: all three functions at once with occasional reset.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 15) == 0);
      counter_en = 1'($urandom);
      alu_vec(3'($urandom), 4'($urandom), 4'($urandom));
      dec_vec(3'($urandom), 1'($urandom));
      clock_counter();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
